decode_stage_pipelined: RTL and testbench
=========================================

Name: decode_stage_pipelined

Overview:
- Registered instruction-decode stage for the RV64-subset datapath.
- Combines control decode, immediate generation and a clocked register file.
- Adds a valid/ready handshake, an ID/EX pipeline register, writeback bypass and a flush input.
- Sits between instruction fetch and execute; parametrised in data width and register count.

Parameters:
- XLEN, 64, datapath and register width in bits (32 or 64).
- NUM_REGS, 32, architectural register count (16 or 32); register index width is 5 bits regardless.
- BYPASS, 1, when 1 a same-cycle writeback to a source register is forwarded to the read data.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- flush  input  1  discards the held and incoming instruction.
- in_valid  input  1  inst is valid.
- in_ready  output  1  stage can accept inst this cycle.
- inst  input  32  instruction word.
- wb_en  input  1  writeback enable.
- wb_rd  input  5  writeback destination.
- wb_data  input  XLEN  writeback value.
- out_valid  output  1  decoded bundle valid.
- out_ready  input  1  execute accepts the bundle.
- rs1_data, rs2_data  output  XLEN  source operands.
- imm_out  output  XLEN  sign-extended immediate.
- rd_out  output  5  destination index.
- alu_op  output  2  00 add, 01 subtract/compare, 10 funct-decoded.
- alu_src, branch, mem_read, mem_write, mem_to_reg, reg_write  output  1 each  control flags.
- illegal  output  1  opcode is not supported.

Behaviour:
- Reset, asynchronous:
  - All registers go to 0.
  - out_valid=0; every registered output goes to 0.
  - Effective at assertion without waiting for clk; state holds at 0 while reset is high.
- Register file:
  - Write on the rising clk edge when wb_en=1 and wb_rd!=0 and wb_rd<NUM_REGS.
  - A write to x0 or an out-of-range index is ignored.
  - Reads are combinational; x0 and indices >= NUM_REGS read 0.
- Bypass:
  - Applies when BYPASS=1, wb_en=1, wb_rd==rs and rs!=0.
  - The captured operand is wb_data instead of the array value.
  - When BYPASS=0 the stale array value is captured.
- Decode:
  - Opcode 0110011 (R): alu_src=0, reg_write=1, alu_op=10, imm=0.
  - Opcode 0010011 (I-ALU): alu_src=1, reg_write=1, alu_op=10, I-immediate.
  - Opcode 0000011 (load): alu_src=1, mem_to_reg=1, reg_write=1, mem_read=1, alu_op=00, I-immediate.
  - Opcode 0100011 (store): alu_src=1, mem_write=1, alu_op=00, S-immediate.
  - Opcode 1100011 (branch): branch=1, alu_op=01, B-immediate with bit0=0.
  - Any other opcode: all flags 0, imm 0, illegal=1.
  - Immediates are sign-extended from inst[31] to XLEN.
  - rd_out=inst[11:7] for all types.
- Handshake:
  - in_ready = !out_valid || out_ready; combinational, independent of in_valid.
  - Transfer occurs when in_valid && in_ready.
  - The pipeline register loads the full decoded bundle and sets out_valid=1.
  - Latency: 1 cycle from transfer to out_valid.
  - When out_valid && out_ready with no new transfer, out_valid clears next cycle.
  - When out_valid && !out_ready, all outputs hold stable; in_ready=0.
  - Back-to-back transfers sustain 1 instruction per cycle when out_ready stays 1.
- Stall hazard: operands are captured only at transfer. A writeback arriving while the bundle is stalled does NOT update held rs1_data/rs2_data; execute-stage forwarding handles that case.
- Flush:
  - flush=1 clears out_valid at the next edge and suppresses any transfer in that cycle.
  - in_ready is forced to 0 while flush=1.
  - Register-file writes still occur during flush.
- States: EMPTY (out_valid=0) and FULL (out_valid=1).
  - EMPTY to FULL on transfer.
  - FULL to EMPTY on out_ready without transfer, or on flush.
  - FULL to FULL on out_ready with transfer, or on stall.
- Mid-operation reset: a held bundle is lost; out_valid=0 immediately.

Test Plan:
- Reset, then read every register via an R-type inst -> all rs data 0, out_valid=0 while reset is high.
- Write x5=0x1234 (wb_en) then issue add x1,x5,x0 -> one cycle later out_valid=1, rs1_data=0x1234, rs2_data=0, alu_op=10, reg_write=1.
- Same cycle: wb_rd=7, wb_data=0xAA, and ld x3,-8(x7) transferred -> rs1_data=0xAA with BYPASS=1 (0 with BYPASS=0), imm_out=all-ones...F8, mem_read=1.
- out_ready=0 for 3 cycles with a beq and a new in_valid -> in_ready=0, outputs stable; out_ready=1 -> next inst loads, branch immediate matches encoding (e.g. offset +16 -> imm 0x10).
- Write x0=0xFF, and wb_rd=20 with NUM_REGS=16 -> both reads return 0; opcode 1111111 -> illegal=1, all flags 0.
- flush asserted with out_valid=1 and in_valid=1 -> next cycle out_valid=0, incoming inst dropped; async reset pulse mid-stall -> out_valid drops without a clk edge.

Source files
------------

// File: rtl/decode_stage_pipelined.sv
// Registered instruction-decode stage: control decode, immediate generation,
// register file with optional writeback bypass, and a valid/ready ID/EX register.
module decode_stage_pipelined #(
    parameter int XLEN     = 64,
    parameter int NUM_REGS = 32,
    parameter int BYPASS   = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     inst,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] rs1_data,
    output logic [XLEN-1:0] rs2_data,
    output logic [XLEN-1:0] imm_out,
    output logic [4:0]      rd_out,
    output logic [1:0]      alu_op,
    output logic            alu_src,
    output logic            branch,
    output logic            mem_read,
    output logic            mem_write,
    output logic            mem_to_reg,
    output logic            reg_write,
    output logic            illegal
);

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I_ALU  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    typedef struct packed {
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [XLEN-1:0] imm;
        logic [4:0]      rd;
        logic [1:0]      alu_op;
        logic            alu_src;
        logic            branch;
        logic            mem_read;
        logic            mem_write;
        logic            mem_to_reg;
        logic            reg_write;
        logic            illegal;
    } bundle_t;

    state_t          state_q, state_d;
    bundle_t         bundle_q, bundle_d, dec_s;
    logic [XLEN-1:0] regs_q [NUM_REGS];
    logic [XLEN-1:0] rs1_arr_s, rs2_arr_s;
    logic [4:0]      rs1_idx_s, rs2_idx_s;
    logic            transfer_s;
    logic            unused_funct3_s;

    // Index is architecturally backed (not x0, below NUM_REGS).
    function automatic logic idx_valid(input logic [4:0] idx);
        return (idx != 5'd0) && ({27'd0, idx} < 32'(NUM_REGS));
    endfunction

    assign rs1_idx_s       = inst[19:15];
    assign rs2_idx_s       = inst[24:20];
    assign unused_funct3_s = ^inst[14:12];

    assign in_ready   = ((state_q == EMPTY) || out_ready) && !flush;
    assign transfer_s = in_valid && in_ready;

    // Register file: x0 and out-of-range indices never take a write.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (wb_en && (wb_rd == 5'(i))) begin
                    regs_q[i] <= wb_data;
                end else begin
                    regs_q[i] <= regs_q[i];
                end
            end
        end
    end

    // Combinational register reads; unmatched indices fall through to zero.
    always_comb begin
        rs1_arr_s = '0;
        rs2_arr_s = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            rs1_arr_s = (rs1_idx_s == 5'(i)) ? regs_q[i] : rs1_arr_s;
            rs2_arr_s = (rs2_idx_s == 5'(i)) ? regs_q[i] : rs2_arr_s;
        end
    end

    // Control decode, immediate generation and operand selection with bypass.
    always_comb begin
        dec_s         = '0;
        dec_s.rd      = inst[11:7];
        case (inst[6:0])
            OPC_R: begin
                dec_s.reg_write = 1'b1;
                dec_s.alu_op    = 2'b10;
            end
            OPC_I_ALU: begin
                dec_s.alu_src   = 1'b1;
                dec_s.reg_write = 1'b1;
                dec_s.alu_op    = 2'b10;
                dec_s.imm       = {{(XLEN-12){inst[31]}}, inst[31:20]};
            end
            OPC_LOAD: begin
                dec_s.alu_src    = 1'b1;
                dec_s.mem_to_reg = 1'b1;
                dec_s.reg_write  = 1'b1;
                dec_s.mem_read   = 1'b1;
                dec_s.alu_op     = 2'b00;
                dec_s.imm        = {{(XLEN-12){inst[31]}}, inst[31:20]};
            end
            OPC_STORE: begin
                dec_s.alu_src   = 1'b1;
                dec_s.mem_write = 1'b1;
                dec_s.alu_op    = 2'b00;
                dec_s.imm       = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                dec_s.branch = 1'b1;
                dec_s.alu_op = 2'b01;
                dec_s.imm    = {{(XLEN-13){inst[31]}}, inst[31], inst[7],
                                inst[30:25], inst[11:8], 1'b0};
            end
            default: begin
                dec_s.illegal = 1'b1;
            end
        endcase
        if ((BYPASS != 0) && wb_en && (wb_rd == rs1_idx_s) && idx_valid(rs1_idx_s)) begin
            dec_s.rs1 = wb_data;
        end else begin
            dec_s.rs1 = rs1_arr_s;
        end
        if ((BYPASS != 0) && wb_en && (wb_rd == rs2_idx_s) && idx_valid(rs2_idx_s)) begin
            dec_s.rs2 = wb_data;
        end else begin
            dec_s.rs2 = rs2_arr_s;
        end
    end

    // Occupancy FSM and bundle load; a stalled bundle keeps its captured operands.
    always_comb begin
        state_d  = state_q;
        bundle_d = bundle_q;
        if (transfer_s) begin
            bundle_d = dec_s;
        end else begin
            bundle_d = bundle_q;
        end
        case (state_q)
            EMPTY: begin
                if (transfer_s) begin
                    state_d = FULL;
                end else begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (flush) begin
                    state_d = EMPTY;
                end else if (transfer_s) begin
                    state_d = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end else begin
                    state_d = FULL;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // ID/EX pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            bundle_q <= '0;
        end else begin
            state_q  <= state_d;
            bundle_q <= bundle_d;
        end
    end

    assign out_valid  = (state_q == FULL);
    assign rs1_data   = bundle_q.rs1;
    assign rs2_data   = bundle_q.rs2;
    assign imm_out    = bundle_q.imm;
    assign rd_out     = bundle_q.rd;
    assign alu_op     = bundle_q.alu_op;
    assign alu_src    = bundle_q.alu_src;
    assign branch     = bundle_q.branch;
    assign mem_read   = bundle_q.mem_read;
    assign mem_write  = bundle_q.mem_write;
    assign mem_to_reg = bundle_q.mem_to_reg;
    assign reg_write  = bundle_q.reg_write;
    assign illegal    = bundle_q.illegal;

endmodule

// File: tb/tb_decode_stage_pipelined.sv
// Scoreboard bench for decode_stage_pipelined: a default instance (32 regs, bypass)
// and a second one (16 regs, no bypass) share stimulus and are checked together.
module tb_decode_stage_pipelined;

    logic        clk = 1'b0;
    logic        reset, flush, in_valid, wb_en, out_ready;
    logic [31:0] inst;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;

    logic        a_in_ready, a_out_valid, a_alu_src, a_branch, a_mem_read, a_mem_write;
    logic        a_mem_to_reg, a_reg_write, a_illegal;
    logic [63:0] a_rs1, a_rs2, a_imm;
    logic [4:0]  a_rd;
    logic [1:0]  a_alu_op;
    logic        b_in_ready, b_out_valid, b_alu_src, b_branch, b_mem_read, b_mem_write;
    logic        b_mem_to_reg, b_reg_write, b_illegal;
    logic [63:0] b_rs1, b_rs2, b_imm;
    logic [4:0]  b_rd;
    logic [1:0]  b_alu_op;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    decode_stage_pipelined #(.XLEN(64), .NUM_REGS(32), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .inst(inst), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .rs1_data(a_rs1), .rs2_data(a_rs2),
        .imm_out(a_imm), .rd_out(a_rd), .alu_op(a_alu_op), .alu_src(a_alu_src),
        .branch(a_branch), .mem_read(a_mem_read), .mem_write(a_mem_write),
        .mem_to_reg(a_mem_to_reg), .reg_write(a_reg_write), .illegal(a_illegal)
    );

    decode_stage_pipelined #(.XLEN(64), .NUM_REGS(16), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .inst(inst), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .rs1_data(b_rs1), .rs2_data(b_rs2),
        .imm_out(b_imm), .rd_out(b_rd), .alu_op(b_alu_op), .alu_src(b_alu_src),
        .branch(b_branch), .mem_read(b_mem_read), .mem_write(b_mem_write),
        .mem_to_reg(b_mem_to_reg), .reg_write(b_reg_write), .illegal(b_illegal)
    );

    // flags order: alu_src, branch, mem_read, mem_write, mem_to_reg, reg_write
    typedef struct packed {
        logic [63:0] rs1_a;
        logic [63:0] rs2_a;
        logic [63:0] rs1_b;
        logic [63:0] rs2_b;
        logic [63:0] imm;
        logic [4:0]  rd;
        logic [1:0]  alu_op;
        logic [5:0]  flags;
        logic        illegal;
    } exp_t;

    exp_t        sb_q[$];
    logic [63:0] mregs_a [32];
    logic [63:0] mregs_b [16];
    bit          mvalid;

    function automatic logic [31:0] enc_r(input logic [4:0] rd, rs1, rs2);
        return {7'b0000000, rs2, rs1, 3'b000, rd, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [6:0] opc, input logic [4:0] rd, rs1,
                                          input logic [11:0] imm);
        return {imm, rs1, 3'b011, rd, opc};
    endfunction
    function automatic logic [31:0] enc_s(input logic [4:0] rs1, rs2, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
    endfunction
    function automatic logic [31:0] enc_b(input logic [4:0] rs1, rs2, input logic [12:0] imm);
        return {imm[12], imm[10:5], rs2, rs1, 3'b000, imm[4:1], imm[11], 7'b1100011};
    endfunction

    function automatic logic [63:0] read_a(input logic [4:0] idx);
        if (idx == 5'd0) return 64'd0;
        if (wb_en && wb_rd == idx) return wb_data;
        return mregs_a[idx];
    endfunction
    function automatic logic [63:0] read_b(input logic [4:0] idx);
        if (idx == 5'd0 || idx >= 5'd16) return 64'd0;
        return mregs_b[idx[3:0]];
    endfunction

    function automatic exp_t expect_for(input logic [31:0] ins);
        exp_t e;
        e = '0;
        e.rd    = ins[11:7];
        e.rs1_a = read_a(ins[19:15]);
        e.rs2_a = read_a(ins[24:20]);
        e.rs1_b = read_b(ins[19:15]);
        e.rs2_b = read_b(ins[24:20]);
        case (ins[6:0])
            7'b0110011: begin e.flags = 6'b000001; e.alu_op = 2'b10; end
            7'b0010011: begin
                e.flags = 6'b100001; e.alu_op = 2'b10;
                e.imm = {{52{ins[31]}}, ins[31:20]};
            end
            7'b0000011: begin
                e.flags = 6'b101011; e.alu_op = 2'b00;
                e.imm = {{52{ins[31]}}, ins[31:20]};
            end
            7'b0100011: begin
                e.flags = 6'b100100; e.alu_op = 2'b00;
                e.imm = {{52{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                e.flags = 6'b010000; e.alu_op = 2'b01;
                e.imm = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            default: e.illegal = 1'b1;
        endcase
        return e;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 32; i++) mregs_a[i] = 64'd0;
        for (int i = 0; i < 16; i++) mregs_b[i] = 64'd0;
        mvalid = 1'b0;
        sb_q.delete();
    endtask

    // One clock of stimulus: predict, clock, then compare against the scoreboard head.
    task automatic step();
        bit   xfer;
        logic exp_rdy;
        exp_t e;
        logic [205:0] got_a, got_b, want_a, want_b;
        #1;
        exp_rdy = (!mvalid || out_ready) && !flush;
        n_checks++;
        if (a_in_ready !== exp_rdy || b_in_ready !== exp_rdy) begin
            n_errors++;
            $display("FAIL in_ready got a=%b b=%b expected %b", a_in_ready, b_in_ready, exp_rdy);
        end
        xfer = in_valid && exp_rdy;
        if (mvalid && (out_ready || flush) && sb_q.size() > 0) void'(sb_q.pop_front());
        if (xfer) sb_q.push_back(expect_for(inst));
        mvalid = xfer || (mvalid && !flush && !out_ready);
        if (wb_en && wb_rd != 5'd0) mregs_a[wb_rd] = wb_data;
        if (wb_en && wb_rd != 5'd0 && wb_rd < 5'd16) mregs_b[wb_rd[3:0]] = wb_data;
        @(posedge clk);
        #1;
        n_checks++;
        if (a_out_valid !== mvalid || b_out_valid !== mvalid) begin
            n_errors++;
            $display("FAIL out_valid got a=%b b=%b expected %b", a_out_valid, b_out_valid, mvalid);
        end
        if (mvalid) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_errors++;
                $display("FAIL scoreboard empty while out_valid expected");
            end else begin
                e      = sb_q[0];
                got_a  = {a_rs1, a_rs2, a_imm, a_rd, a_alu_op,
                          a_alu_src, a_branch, a_mem_read, a_mem_write, a_mem_to_reg,
                          a_reg_write, a_illegal};
                got_b  = {b_rs1, b_rs2, b_imm, b_rd, b_alu_op,
                          b_alu_src, b_branch, b_mem_read, b_mem_write, b_mem_to_reg,
                          b_reg_write, b_illegal};
                want_a = {e.rs1_a, e.rs2_a, e.imm, e.rd, e.alu_op, e.flags, e.illegal};
                want_b = {e.rs1_b, e.rs2_b, e.imm, e.rd, e.alu_op, e.flags, e.illegal};
                if (got_a !== want_a || got_b !== want_b) begin
                    n_errors++;
                    $display("FAIL bundle inst-bypass got %h expected %h", got_a, want_a);
                    $display("FAIL bundle no-bypass got %h expected %h", got_b, want_b);
                end
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
        wb_en = 1'b0; wb_rd = 5'd0; wb_data = 64'd0;
        inst = enc_r(5'd1, 5'd2, 5'd3);
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_rs1 !== 64'd0 || a_imm !== 64'd0) begin
            n_errors++;
            $display("FAIL reset_state got valid=%b rs1=%h imm=%h expected 0", a_out_valid, a_rs1, a_imm);
        end
        reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            inst = enc_r(5'd1, 5'(i), 5'(31 - i));
            step();
            n_checks++;
            if (a_rs1 !== 64'd0 || a_rs2 !== 64'd0) begin
                n_errors++;
                $display("FAIL reset_regread x%0d got %h/%h expected 0", i, a_rs1, a_rs2);
            end
        end
    endtask

    task automatic test_write_read();
        in_valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'h1234;
        step();
        wb_en = 1'b0; in_valid = 1'b1; inst = enc_r(5'd1, 5'd5, 5'd0);
        step();
        n_checks++;
        if (a_out_valid !== 1'b1 || a_rs1 !== 64'h1234 || a_rs2 !== 64'd0 ||
            a_alu_op !== 2'b10 || a_reg_write !== 1'b1) begin
            n_errors++;
            $display("FAIL write_read got v=%b rs1=%h rs2=%h op=%b rw=%b expected 1/1234/0/10/1",
                     a_out_valid, a_rs1, a_rs2, a_alu_op, a_reg_write);
        end
    endtask

    task automatic test_bypass();
        wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'hAA; in_valid = 1'b1;
        inst = enc_i(7'b0000011, 5'd3, 5'd7, 12'hFF8);
        step();
        wb_en = 1'b0;
        n_checks++;
        if (a_rs1 !== 64'hAA || b_rs1 !== 64'd0 || a_imm !== 64'hFFFF_FFFF_FFFF_FFF8 ||
            a_mem_read !== 1'b1) begin
            n_errors++;
            $display("FAIL bypass got a_rs1=%h b_rs1=%h imm=%h mr=%b expected aa/0/..fff8/1",
                     a_rs1, b_rs1, a_imm, a_mem_read);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b1; in_valid = 1'b1; inst = enc_s(5'd5, 5'd6, 12'hFFC);
        step();
        out_ready = 1'b0; inst = enc_b(5'd5, 5'd1, 13'd16);
        wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'hDEAD;
        for (int i = 0; i < 3; i++) begin
            step();
            wb_en = 1'b0;
            n_checks++;
            if (a_rs1 !== 64'h1234 || a_imm !== 64'hFFFF_FFFF_FFFF_FFFC || a_mem_write !== 1'b1) begin
                n_errors++;
                $display("FAIL stall_hold got rs1=%h imm=%h mw=%b expected 1234/..fffc/1",
                         a_rs1, a_imm, a_mem_write);
            end
        end
        out_ready = 1'b1;
        step();
        n_checks++;
        if (a_imm !== 64'h10 || a_branch !== 1'b1 || a_rs1 !== 64'hDEAD || a_alu_op !== 2'b01) begin
            n_errors++;
            $display("FAIL stall_release got imm=%h br=%b rs1=%h op=%b expected 10/1/dead/01",
                     a_imm, a_branch, a_rs1, a_alu_op);
        end
    endtask

    task automatic test_bounds();
        in_valid = 1'b0; wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'hFF;
        step();
        wb_rd = 5'd20; wb_data = 64'h55;
        step();
        wb_en = 1'b0; in_valid = 1'b1; inst = enc_r(5'd2, 5'd0, 5'd20);
        step();
        n_checks++;
        if (a_rs1 !== 64'd0 || b_rs1 !== 64'd0 || b_rs2 !== 64'd0 || a_rs2 !== 64'h55) begin
            n_errors++;
            $display("FAIL bounds got a=%h/%h b=%h/%h expected 0/55 0/0", a_rs1, a_rs2, b_rs1, b_rs2);
        end
        inst = 32'hFFFF_FFFF;
        step();
        n_checks++;
        if (a_illegal !== 1'b1 || a_imm !== 64'd0 || a_alu_op !== 2'b00 ||
            {a_alu_src, a_branch, a_mem_read, a_mem_write, a_mem_to_reg, a_reg_write} !== 6'd0) begin
            n_errors++;
            $display("FAIL illegal got ill=%b imm=%h op=%b expected 1/0/00 flags 0",
                     a_illegal, a_imm, a_alu_op);
        end
    endtask

    task automatic test_flush();
        in_valid = 1'b1; out_ready = 1'b0; inst = enc_i(7'b0010011, 5'd4, 5'd1, 12'h123);
        step();
        flush = 1'b1; inst = enc_r(5'd6, 5'd7, 5'd8);
        wb_en = 1'b1; wb_rd = 5'd9; wb_data = 64'h99;
        step();
        flush = 1'b0; in_valid = 1'b0; wb_en = 1'b0; out_ready = 1'b1;
        step();
        n_checks++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL flush_drop got a=%b b=%b expected 0", a_out_valid, b_out_valid);
        end
        in_valid = 1'b1; inst = enc_r(5'd2, 5'd9, 5'd0);
        step();
        n_checks++;
        if (a_rs1 !== 64'h99 || b_rs1 !== 64'h99) begin
            n_errors++;
            $display("FAIL flush_wb got a=%h b=%h expected 99", a_rs1, b_rs1);
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0; in_valid = 1'b1; inst = enc_r(5'd3, 5'd5, 5'd9);
        step();
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (a_out_valid !== 1'b0 || b_out_valid !== 1'b0 || a_rs1 !== 64'd0) begin
            n_errors++;
            $display("FAIL async_reset got a=%b b=%b rs1=%h expected 0/0/0", a_out_valid, b_out_valid, a_rs1);
        end
        @(posedge clk);
        #1;
        reset = 1'b0; out_ready = 1'b1;
        clear_model();
        inst = enc_r(5'd3, 5'd5, 5'd9);
        step();
    endtask

    task automatic test_back_to_back();
        logic [4:0]  r1, r2, rdst;
        logic [11:0] im;
        for (int n = 0; n < 60; n++) begin
            r1 = 5'($urandom_range(0, 31)); r2 = 5'($urandom_range(0, 31));
            rdst = 5'($urandom_range(0, 31)); im = 12'($urandom);
            case ($urandom_range(0, 5))
                0: inst = enc_r(rdst, r1, r2);
                1: inst = enc_i(7'b0010011, rdst, r1, im);
                2: inst = enc_i(7'b0000011, rdst, r1, im);
                3: inst = enc_s(r1, r2, im);
                4: inst = enc_b(r1, r2, {im, 1'b0});
                default: inst = $urandom;
            endcase
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 9) == 0);
            wb_en     = ($urandom_range(0, 1) != 0);
            wb_rd     = ($urandom_range(0, 1) != 0) ? r1 : 5'($urandom_range(0, 31));
            wb_data   = {$urandom, $urandom};
            step();
        end
        flush = 1'b0; wb_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_bypass();
        test_stall();
        test_bounds();
        test_flush();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
